// File: rtl/txn_pkg.sv
// rtl/txn_pkg.sv - shared status codes and FSM state encodings for the transaction engine
//
// Purpose: common definitions imported by txn_engine_if, txn_key_hash and txn_engine.
//   STATUS_W      : width of the status code
//   ST_OK..ST_BAD_KEY : status codes reported with done
//   state_t       : transaction FSM states (IDLE, CHECK, HASH, COMMIT, DONE)
package txn_pkg;

  localparam int STATUS_W = 3;

  localparam logic [STATUS_W-1:0] ST_OK        = 3'd0;
  localparam logic [STATUS_W-1:0] ST_BAD_INDEX = 3'd1;
  localparam logic [STATUS_W-1:0] ST_SAME_ACCT = 3'd2;
  localparam logic [STATUS_W-1:0] ST_NO_FUNDS  = 3'd3;
  localparam logic [STATUS_W-1:0] ST_OVERFLOW  = 3'd4;
  localparam logic [STATUS_W-1:0] ST_BAD_KEY   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    HASH   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/txn_engine_if.sv
// rtl/txn_engine_if.sv - controller-side bus of the transaction engine
//
// Purpose: groups the account-file load, transfer request and result signals.
// Signals:
//   load_state, balances_in, pubkeys_in : register-file load (IDLE only)
//   random_table                        : per-round hash constants
//   start, sender, receiver, amount, priv_key : transfer request
//   busy, done, status, balances_out    : engine result
// Modports: master = controller side, slave = engine side.
interface txn_engine_if
  import txn_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int AMT_W       = 8,
  parameter int KEY_W       = 8,
  parameter int HASH_ROUNDS = 4,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
);

  logic                           load_state;
  logic [NUM_PLAYERS*AMT_W-1:0]   balances_in;
  logic [NUM_PLAYERS*KEY_W-1:0]   pubkeys_in;
  logic [HASH_ROUNDS*KEY_W-1:0]   random_table;
  logic                           start;
  logic [IDX_W-1:0]               sender;
  logic [IDX_W-1:0]               receiver;
  logic [AMT_W-1:0]               amount;
  logic [KEY_W-1:0]               priv_key;
  logic                           busy;
  logic                           done;
  logic [STATUS_W-1:0]            status;
  logic [NUM_PLAYERS*AMT_W-1:0]   balances_out;

  modport master (
    output load_state, balances_in, pubkeys_in, random_table,
    output start, sender, receiver, amount, priv_key,
    input  busy, done, status, balances_out
  );

  modport slave (
    input  load_state, balances_in, pubkeys_in, random_table,
    input  start, sender, receiver, amount, priv_key,
    output busy, done, status, balances_out
  );

endinterface

// File: rtl/txn_key_hash.sv
// rtl/txn_key_hash.sv - iterative rotate-xor key hasher
//
// Purpose: h <= rotl(h,1) ^ random_table[round] for HASH_ROUNDS rounds.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   go            : load key_in and restart at round 0
//   key_in        : starting value of h
//   random_table  : per-round constants, round r at [r*KEY_W +: KEY_W]
//   key_out       : h after the current round (final hash when hash_done=1)
//   hash_done     : high during the cycle that computes the last round
// KEY_W must be at least 2.
module txn_key_hash #(
  parameter int KEY_W       = 8,
  parameter int HASH_ROUNDS = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         go,
  input  logic [KEY_W-1:0]             key_in,
  input  logic [HASH_ROUNDS*KEY_W-1:0] random_table,
  output logic [KEY_W-1:0]             key_out,
  output logic                         hash_done
);

  localparam int RND_W = $clog2(HASH_ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(HASH_ROUNDS - 1);

  logic [KEY_W-1:0] r_h;
  logic [RND_W-1:0] r_round;
  logic             r_active;

  logic [KEY_W-1:0] w_const;
  logic [KEY_W-1:0] w_h_next;
  logic             w_last;

  assign w_const  = random_table[int'(r_round)*KEY_W +: KEY_W];
  assign w_h_next = {r_h[KEY_W-2:0], r_h[KEY_W-1]} ^ w_const;
  assign w_last   = r_active && (r_round == LAST_ROUND);

  // The last round is presented combinationally so the caller can compare
  // and leave HASH on the same edge, giving exactly HASH_ROUNDS cycles there.
  assign key_out   = w_h_next;
  assign hash_done = w_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h      <= '0;
      r_round  <= '0;
      r_active <= 1'b0;
    end else if (go) begin
      r_h      <= key_in;
      r_round  <= '0;
      r_active <= 1'b1;
    end else if (w_last) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      r_h     <= w_h_next;
      r_round <= r_round + 1'b1;
    end
  end

endmodule

// File: rtl/txn_engine.sv
// rtl/txn_engine.sv - multi-account transfer engine with key check and commit
//
// Purpose: holds balances/public keys and runs CHECK -> HASH -> COMMIT -> DONE.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   bus          : txn_engine_if.slave (load, request, busy/done/status, balances_out)
// Optional macro TXN_FEE_EN: adds parameter FEE; sender pays amount+FEE, fee is burned.
module txn_engine
  import txn_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int AMT_W       = 8,
  parameter int KEY_W       = 8,
  parameter int HASH_ROUNDS = 4,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
`ifdef TXN_FEE_EN
  ,
  parameter int FEE         = 1
`endif
) (
  input  logic         clock,
  input  logic         reset,
  txn_engine_if.slave  bus
);

  localparam int SEL_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [IDX_W:0] NP = (IDX_W + 1)'(NUM_PLAYERS);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [STATUS_W-1:0] r_status;
  logic [AMT_W-1:0]    r_bal [NUM_PLAYERS];
  logic [KEY_W-1:0]    r_pub [NUM_PLAYERS];
  logic [IDX_W-1:0]    r_sender;
  logic [IDX_W-1:0]    r_receiver;
  logic [AMT_W-1:0]    r_amount;
  logic [KEY_W-1:0]    r_priv_key;

  logic [SEL_W-1:0]    w_s_sel;
  logic [SEL_W-1:0]    w_r_sel;
  logic [AMT_W-1:0]    w_bal_s;
  logic [AMT_W-1:0]    w_bal_r;
  logic [AMT_W:0]      w_debit;
  logic [AMT_W:0]      w_credit_sum;
  logic [STATUS_W-1:0] w_chk_status;
  logic                w_hash_go;
  logic                w_hash_done;
  logic [KEY_W-1:0]    w_key_out;

  // Out-of-range indices still select some entry here; the result is only
  // used once the index check has passed.
  assign w_s_sel = r_sender[SEL_W-1:0];
  assign w_r_sel = r_receiver[SEL_W-1:0];
  assign w_bal_s = r_bal[w_s_sel];
  assign w_bal_r = r_bal[w_r_sel];

`ifdef TXN_FEE_EN
  assign w_debit = {1'b0, r_amount} + (AMT_W + 1)'(FEE);
`else
  assign w_debit = {1'b0, r_amount};
`endif
  assign w_credit_sum = {1'b0, w_bal_r} + {1'b0, r_amount};

  always_comb begin
    w_chk_status = ST_OK;
    if (({1'b0, r_sender} >= NP) || ({1'b0, r_receiver} >= NP)) begin
      w_chk_status = ST_BAD_INDEX;
    end else if (r_sender == r_receiver) begin
      w_chk_status = ST_SAME_ACCT;
    end else if (w_debit > {1'b0, w_bal_s}) begin
      w_chk_status = ST_NO_FUNDS;
    end else if (w_credit_sum[AMT_W]) begin
      w_chk_status = ST_OVERFLOW;
    end
  end

  assign w_hash_go = (r_state == CHECK) && (w_chk_status == ST_OK);

  txn_key_hash #(
    .KEY_W       (KEY_W),
    .HASH_ROUNDS (HASH_ROUNDS)
  ) u_key_hash (
    .clock        (clock),
    .reset        (reset),
    .go           (w_hash_go),
    .key_in       (r_priv_key),
    .random_table (bus.random_table),
    .key_out      (w_key_out),
    .hash_done    (w_hash_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_status   <= ST_OK;
      r_sender   <= '0;
      r_receiver <= '0;
      r_amount   <= '0;
      r_priv_key <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_bal[i] <= '0;
        r_pub[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // start wins over a simultaneous load_state
          if (bus.start) begin
            r_sender   <= bus.sender;
            r_receiver <= bus.receiver;
            r_amount   <= bus.amount;
            r_priv_key <= bus.priv_key;
            r_busy     <= 1'b1;
            r_state    <= CHECK;
          end else if (bus.load_state) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              r_bal[i] <= bus.balances_in[i*AMT_W +: AMT_W];
              r_pub[i] <= bus.pubkeys_in[i*KEY_W +: KEY_W];
            end
          end
        end
        CHECK: begin
          if (w_chk_status != ST_OK) begin
            r_status <= w_chk_status;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state <= HASH;
          end
        end
        HASH: begin
          if (w_hash_done) begin
            if (w_key_out == r_pub[w_s_sel]) begin
              r_state <= COMMIT;
            end else begin
              r_status <= ST_BAD_KEY;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        COMMIT: begin
          r_bal[w_s_sel] <= w_bal_s - w_debit[AMT_W-1:0];
          r_bal[w_r_sel] <= w_credit_sum[AMT_W-1:0];
          r_status       <= ST_OK;
          r_done         <= 1'b1;
          r_state        <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.status = r_status;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_bal_out
    assign bus.balances_out[g*AMT_W +: AMT_W] = r_bal[g];
  end

endmodule

// File: tb/tb_txn_engine.sv
// tb/tb_txn_engine.sv - scoreboard bench for txn_engine
module tb_txn_engine;
  import txn_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 8;
  localparam int KW  = 8;
  localparam int HR  = 4;
  localparam int IW  = 3;
`ifdef TXN_FEE_EN
  localparam int FEE_M = 1;
`else
  localparam int FEE_M = 0;
`endif

  typedef struct {
    logic [2:0]  st;
    logic [31:0] bal;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [7:0] m_bal [NP];

  txn_engine_if #(.NUM_PLAYERS(NP), .AMT_W(AW), .KEY_W(KW), .HASH_ROUNDS(HR), .IDX_W(IW)) bus ();

  txn_engine #(.NUM_PLAYERS(NP), .AMT_W(AW), .KEY_W(KW), .HASH_ROUNDS(HR), .IDX_W(IW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_model();
    logic [31:0] p;
    for (int i = 0; i < NP; i++) p[i*8 +: 8] = m_bal[i];
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("status", 32'(bus.status), 32'(e.st));
        chk("balances", bus.balances_out, e.bal);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic load_file(input logic [31:0] bal, input logic [31:0] pub);
    @(negedge clock);
    bus.balances_in = bal;
    bus.pubkeys_in  = pub;
    bus.load_state  = 1'b1;
    @(negedge clock);
    bus.load_state  = 1'b0;
    for (int i = 0; i < NP; i++) m_bal[i] = bal[i*8 +: 8];
    chk("load_balances", bus.balances_out, bal);
  endtask

  // mode 0: plain; 1: load_state together with start; 2: load_state while busy
  task automatic do_txn(input logic [2:0] s, input logic [2:0] r, input logic [7:0] amt,
                        input logic [7:0] key, input logic [2:0] st, input int mode);
    exp_t e;
    int   lat;
    lat = (st == ST_OK) ? HR + 3 : (st == ST_BAD_KEY) ? HR + 2 : 2;
    @(negedge clock);
    bus.sender   = s;
    bus.receiver = r;
    bus.amount   = amt;
    bus.priv_key = key;
    bus.start    = 1'b1;
    if (mode == 1) begin
      bus.balances_in = 32'hFFFF_FFFF;
      bus.load_state  = 1'b1;
    end
    if (st == ST_OK) begin
      m_bal[int'(s)] = m_bal[int'(s)] - amt - 8'(FEE_M);
      m_bal[int'(r)] = m_bal[int'(r)] + amt;
    end
    e.st  = st;
    e.bal = pack_model();
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clock);
    bus.start      = 1'b0;
    bus.load_state = 1'b0;
    bus.sender     = ~s;
    bus.receiver   = ~r;
    bus.amount     = ~amt;
    bus.priv_key   = ~key;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    if (mode == 2) begin
      bus.balances_in = 32'hFFFF_FFFF;
      bus.load_state  = 1'b1;
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    bus.load_state = 1'b0;
    chk("result_seen", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clock);
    chk("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.load_state   = 1'b0;
    bus.balances_in  = '0;
    bus.pubkeys_in   = '0;
    bus.random_table = '0;
    bus.start        = 1'b0;
    bus.sender       = '0;
    bus.receiver     = '0;
    bus.amount       = '0;
    bus.priv_key     = '0;
    for (int i = 0; i < NP; i++) m_bal[i] = 8'd0;

    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_balances", bus.balances_out, 32'd0);
    reset = 1'b0;

    // bal {10,20,30,40}; pub {0x21,0xA3,0x54,0x0F} -> keys 0x12,0x3A,0x45,0xF0
    load_file({8'd40, 8'd30, 8'd20, 8'd10}, 32'h0F54_A321);
    do_txn(3'd1, 3'd3, 8'd5, 8'h3A, ST_OK, 0);
    chk("tp1_balances", bus.balances_out,
        (FEE_M == 0) ? {8'd45, 8'd30, 8'd15, 8'd10} : {8'd45, 8'd30, 8'd14, 8'd10});
    do_txn(3'd1, 3'd3, 8'd5, 8'h3B, ST_BAD_KEY, 0);
    do_txn(3'd0, 3'd1, 8'd11, 8'h12, ST_NO_FUNDS, 0);
    do_txn(3'd0, 3'd1, 8'(10 - FEE_M), 8'h12, ST_OK, 0);
    chk("drain_to_zero", 32'(bus.balances_out[7:0]), 32'd0);
    do_txn(3'd2, 3'd2, 8'd1, 8'h45, ST_SAME_ACCT, 0);
    do_txn(3'd5, 3'd1, 8'd1, 8'h00, ST_BAD_INDEX, 0);
    do_txn(3'd1, 3'd4, 8'd1, 8'h3A, ST_BAD_INDEX, 0);
    do_txn(3'd5, 3'd5, 8'd1, 8'h00, ST_BAD_INDEX, 0);
    do_txn(3'd0, 3'd0, 8'd200, 8'h12, ST_SAME_ACCT, 0);
    do_txn(3'd0, 3'd1, 8'd1, 8'h00, ST_NO_FUNDS, 0);
    do_txn(3'd3, 3'd0, 8'd0, 8'hF0, ST_OK, 0);

    load_file({8'd40, 8'd250, 8'd20, 8'd100}, 32'h0F54_A321);
    do_txn(3'd0, 3'd2, 8'd6, 8'h12, ST_OVERFLOW, 0);
    do_txn(3'd0, 3'd2, 8'd5, 8'h12, ST_OK, 0);
    chk("fill_to_max", 32'(bus.balances_out[23:16]), 32'd255);
    do_txn(3'd1, 3'd0, 8'd1, 8'h3A, ST_OK, 1);
    do_txn(3'd3, 3'd1, 8'd2, 8'hF0, ST_OK, 2);

    load_file({8'd0, 8'd0, 8'd5, 8'd0}, 32'h0F54_A321);
    do_txn(3'd1, 3'd0, 8'd5, 8'h3A, (FEE_M == 0) ? ST_OK : ST_NO_FUNDS, 0);
    do_txn(3'd1, 3'd0, 8'd4, 8'h3A, (FEE_M == 0) ? ST_NO_FUNDS : ST_OK, 0);

    // Reset in the middle of HASH aborts with no commit and no done.
    load_file({8'd40, 8'd30, 8'd20, 8'd10}, 32'h0F54_A321);
    @(negedge clock);
    bus.sender   = 3'd1;
    bus.receiver = 3'd3;
    bus.amount   = 8'd5;
    bus.priv_key = 8'h3A;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_status", 32'(bus.status), 32'd0);
    chk("abort_balances", bus.balances_out, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NP; i++) m_bal[i] = 8'd0;
    repeat (10) @(negedge clock);
    chk("abort_stays_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/txn_engine.md
Name: txn_engine

Overview:
- Parametrised successor to the two-player transaction datapath; supports NUM_PLAYERS accounts with configurable amount and key widths.
- Holds the balance and public-key register file itself and runs a multi-cycle transfer: bounds/funds check, iterative key hash, commit.
- Reports done plus a status code.
- Sits between the top-level control FSM and memory: memory loads the account file, the controller issues start, and the result is written back via balances_out.

Parameters:
NUM_PLAYERS, 4, number of accounts (>=2)
AMT_W, 8, balance/amount width, unsigned
KEY_W, 8, key width
HASH_ROUNDS, 4, key-hash iterations (>=1)
IDX_W, $clog2(NUM_PLAYERS), account index width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
load_state  in  1  load balances_in/pubkeys_in into register file (honoured only in IDLE)
balances_in  in  NUM_PLAYERS*AMT_W  flat balances, account i at [i*AMT_W +: AMT_W]
pubkeys_in  in  NUM_PLAYERS*KEY_W  flat public keys, same packing
random_table  in  HASH_ROUNDS*KEY_W  per-round hash constants, round r at [r*KEY_W +: KEY_W]
start  in  1  request transfer (sampled only in IDLE)
sender  in  IDX_W  paying account
receiver  in  IDX_W  receiving account
amount  in  AMT_W  transfer amount
priv_key  in  KEY_W  sender's claimed private key
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of transaction
status  out  3  0 OK, 1 BAD_INDEX, 2 SAME_ACCT, 3 NO_FUNDS, 4 OVERFLOW, 5 BAD_KEY; valid while done=1, held until next start
balances_out  out  NUM_PLAYERS*AMT_W  current register file, same packing

Behaviour:
- Reset state: state IDLE; all balances and pubkeys 0; busy=0; done=0; status=0. Reset mid-transaction aborts with no commit.
- Capture: start in IDLE latches sender, receiver, amount and priv_key into internal registers. Input changes after capture are ignored.
- States:
  - IDLE: waits for start. start has priority over a simultaneous load_state, which is dropped. load_state outside IDLE is ignored.
  - CHECK (1 cycle): checks run in priority order; first failure sets status and goes to DONE.
    - sender>=NUM_PLAYERS or receiver>=NUM_PLAYERS -> BAD_INDEX
    - sender==receiver -> SAME_ACCT
    - amount > bal[sender] -> NO_FUNDS (amount==bal allowed)
    - bal[receiver]+amount overflows AMT_W -> OVERFLOW (no saturation, no wrap)
    - otherwise -> HASH with h=priv_key, round=0.
  - HASH (HASH_ROUNDS cycles): each cycle h <= rotl(h,1) ^ table[round]; round++. After the last round: if h==pubkey[sender], go to COMMIT, else set BAD_KEY and go to DONE.
  - COMMIT (1 cycle): bal[sender] -= amount; bal[receiver] += amount, in the same edge. status=OK.
  - DONE (1 cycle): done=1, then IDLE. start is ignored in DONE.
- Latency, counted from the start edge:
  - done is high in cycle HASH_ROUNDS+3 on success.
  - done is high in cycle HASH_ROUNDS+2 on BAD_KEY.
  - done is high in cycle 2 on CHECK failures.
- amount==0 with valid, distinct indices and a correct key is a legal no-op: status OK.
- balances_out changes only on the COMMIT edge or on load_state.

Optional Feature:
- Macro TXN_FEE_EN.
- Defined:
  - Adds parameter FEE (default 1).
  - The funds check becomes amount+FEE > bal[sender], computed at AMT_W+1 bits, failing with NO_FUNDS.
  - COMMIT debits amount+FEE from the sender and credits amount to the receiver; the fee is burned.
- Undefined: no fee logic or parameter; behaviour as above.

Decomposition:
- Package txn_pkg holds:
  - the status code localparams (ST_OK..ST_BAD_KEY);
  - the FSM state encodings (IDLE, CHECK, HASH, COMMIT, DONE);
  - the status width of 3.
- Sub-module txn_key_hash: iterative rotate-xor hasher.
  - Ports: clock, reset, go, key_in, random_table, key_out, hash_done.
  - The FSM holds in HASH until hash_done.

Test Plan (NUM_PLAYERS=4, AMT_W=8, KEY_W=8, HASH_ROUNDS=4, random_table=0, so hash = nibble swap):
- Load bal={10,20,30,40}, pub[1]=0xA3. Start sender=1, receiver=3, amount=5, key=0x3A -> done at cycle 7, status 0, bal={10,15,30,45}.
- Same setup with key=0x3B -> done at cycle 6, status 5, balances unchanged.
- sender=0, amount=11 with bal[0]=10 -> done at cycle 2, status 3. Then amount=10 with a valid key -> status 0, bal[0]=0.
- bal[2]=250, transfer of 6 into account 2 -> status 4. Also sender=receiver=2 -> status 2; sender=5 (with NUM_PLAYERS=4) -> status 1.
- Reset asserted during HASH -> next cycle busy=0, done=0, all balances 0. load_state during busy is ignored; start and load_state together in IDLE -> the transfer runs and the load is dropped.
- With TXN_FEE_EN and FEE=1, bal[1]=5, amount=5 -> status 3. With amount=4 -> bal[1]=0, receiver +4.
